// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and framing constants for uart_word_bridge.
// Defines the RX/TX FSM state enums, BYTES_PER_WORD, and the frame length.
// Optional feature macro UART_WORD_CHECKSUM_EN: when defined, each frame gets a
// fifth byte that is the XOR of the four data bytes.
package uart_pkg;
    typedef enum logic [1:0] {R_COLLECT, R_GAP, R_HOLD} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;
    localparam int BYTES_PER_WORD = 4;
`ifdef UART_WORD_CHECKSUM_EN
    localparam int FRAME_BYTES = BYTES_PER_WORD + 1;
`else
    localparam int FRAME_BYTES = BYTES_PER_WORD;
`endif
    localparam int IDX_W = 3;
endpackage

// File: rtl/byte_xor_reduce.sv
// byte_xor_reduce: XOR of the four bytes of a 32-bit word (frame checksum).
// Ports: word - 32-bit input word; x - 8-bit XOR of its byte lanes.
module byte_xor_reduce (
    input  logic [31:0] word,
    output logic [7:0]  x
);
    assign x = word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
endmodule

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: packs UART FIFO bytes into 32-bit words and unpacks words into bytes.
// Ports: CLK/RST (async, active-high); recv_data/receivable/recv_flag pop the UART
// receive FIFO; send_data/send_flag/sendable push the UART transmit FIFO;
// rx_word/rx_valid/rx_ready carry assembled words out; tx_word/tx_valid/tx_ready
// take words in; rx_err pulses when a received frame fails its checksum.
// Parameter TIMEOUT: idle cycles after which a partially received word is dropped.
// Macro UART_WORD_CHECKSUM_EN: frames carry a fifth XOR byte, checked on RX and
// appended on TX; otherwise frames are 4 bytes and rx_err is tied low.
module uart_word_bridge
    import uart_pkg::*;
#(
    parameter int TIMEOUT = 2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  recv_data,
    input  logic        receivable,
    output logic        recv_flag,
    output logic [7:0]  send_data,
    output logic        send_flag,
    input  logic        sendable,
    output logic [31:0] rx_word,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] tx_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        rx_err
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    rx_state_t        rx_state, rx_next;
    tx_state_t        tx_state, tx_next;
    logic [IDX_W-1:0] rx_idx, tx_idx;
    logic [TO_W-1:0]  to_cnt;
    logic [31:0]      tx_buf;
    logic [7:0]       tx_byte;
    logic             pop, push, rx_last, rx_ok, rx_to, tx_last;

    assign pop     = rx_state == R_COLLECT && receivable;
    assign push    = tx_state == T_SEND && sendable;
    assign rx_last = rx_idx == IDX_W'(FRAME_BYTES);
    assign tx_last = tx_idx == IDX_W'(FRAME_BYTES);
    // Partial word expires only while waiting for a byte that never comes.
    assign rx_to   = rx_state == R_COLLECT && !receivable && rx_idx != '0 &&
                     to_cnt == TO_W'(TIMEOUT - 1);

`ifdef UART_WORD_CHECKSUM_EN
    logic [7:0] rx_chk, rx_sum, tx_sum;
    byte_xor_reduce u_rx_xor (.word(rx_word), .x(rx_sum));
    byte_xor_reduce u_tx_xor (.word(tx_buf),  .x(tx_sum));
    assign rx_ok   = rx_sum == rx_chk;
    assign tx_byte = tx_idx[2] ? tx_sum : tx_buf[{tx_idx[1:0], 3'b000} +: 8];
`else
    assign rx_ok   = 1'b1;
    assign tx_byte = tx_buf[{tx_idx[1:0], 3'b000} +: 8];
    assign rx_err  = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST)
        if (RST) rx_state <= R_COLLECT;
        else rx_state <= rx_next;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_COLLECT: rx_next = pop ? R_GAP : R_COLLECT;
            R_GAP:     rx_next = rx_last && rx_ok ? R_HOLD : R_COLLECT;
            R_HOLD:    rx_next = rx_ready ? R_COLLECT : R_HOLD;
            default:   rx_next = R_COLLECT;
        endcase
    end

    // The pop pulse is issued in R_GAP, one cycle after the byte was latched,
    // so the FIFO head has advanced before R_COLLECT samples it again.
    always_comb begin
        recv_flag = rx_state == R_GAP;
        rx_valid  = rx_state == R_HOLD;
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            rx_idx  <= '0;
            rx_word <= '0;
            to_cnt  <= '0;
`ifdef UART_WORD_CHECKSUM_EN
            rx_chk  <= '0;
            rx_err  <= 1'b0;
`endif
        end else begin
`ifdef UART_WORD_CHECKSUM_EN
            rx_err <= 1'b0;
`endif
            if (pop) begin
`ifdef UART_WORD_CHECKSUM_EN
                if (rx_idx[2]) rx_chk <= recv_data;
                else rx_word[{rx_idx[1:0], 3'b000} +: 8] <= recv_data;
`else
                rx_word[{rx_idx[1:0], 3'b000} +: 8] <= recv_data;
`endif
                rx_idx <= rx_idx + 1'b1;
                to_cnt <= '0;
            end else if (rx_to) begin
                rx_idx <= '0;
                to_cnt <= '0;
            end else if (rx_state == R_COLLECT && rx_idx != '0)
                to_cnt <= to_cnt + 1'b1;
            if (rx_state == R_GAP && rx_last) begin
                rx_idx <= '0;
`ifdef UART_WORD_CHECKSUM_EN
                rx_err <= !rx_ok;
`endif
            end
        end

    always_ff @(posedge CLK or posedge RST)
        if (RST) tx_state <= T_IDLE;
        else tx_state <= tx_next;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  tx_next = tx_valid ? T_SEND : T_IDLE;
            T_SEND:  tx_next = sendable ? T_GAP : T_SEND;
            T_GAP:   tx_next = tx_last ? T_IDLE : T_SEND;
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_ready  = tx_state == T_IDLE;
        send_flag = tx_state == T_GAP;
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            tx_idx    <= '0;
            tx_buf    <= '0;
            send_data <= '0;
        end else if (tx_ready && tx_valid) begin
            tx_buf <= tx_word;
            tx_idx <= '0;
        end else if (push) begin
            send_data <= tx_byte;
            tx_idx    <= tx_idx + 1'b1;
        end
endmodule

// File: tb/tb_uart_word_bridge.sv
// tb_uart_word_bridge: scoreboard bench for uart_word_bridge with FIFO models on both UART sides.
module tb_uart_word_bridge;
    localparam int TO = 40;
`ifdef UART_WORD_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        CLK = 1'b0, RST = 1'b1;
    logic [7:0]  recv_data = 8'h00;
    logic        receivable = 1'b0, sendable = 1'b1, rx_ready = 1'b0, tx_valid = 1'b0;
    logic [31:0] tx_word = '0;
    logic        recv_flag, send_flag, rx_valid, tx_ready, rx_err;
    logic [7:0]  send_data;
    logic [31:0] rx_word;

    logic [7:0]  rx_fifo[$];
    logic [7:0]  tx_seen[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rx[$];
    int checks = 0, failures = 0, pops = 0, pushes = 0, errs = 0, gap_viol = 0;
    logic prev_r = 1'b0, prev_s = 1'b0;

    uart_word_bridge #(.TIMEOUT(TO)) u_dut (
        .CLK(CLK), .RST(RST), .recv_data(recv_data), .receivable(receivable),
        .recv_flag(recv_flag), .send_data(send_data), .send_flag(send_flag),
        .sendable(sendable), .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_err(rx_err)
    );

    always #5 CLK = ~CLK;

    // UART FIFO models, updated away from the active edge.
    always @(negedge CLK) begin
        if (recv_flag) begin
            pops++;
            if (rx_fifo.size() != 0) void'(rx_fifo.pop_front());
        end
        if (send_flag) begin
            pushes++;
            tx_seen.push_back(send_data);
        end
        if (rx_err) errs++;
        if ((recv_flag && prev_r) || (send_flag && prev_s)) gap_viol++;
        prev_r = recv_flag;
        prev_s = send_flag;
        receivable = rx_fifo.size() != 0;
        recv_data = rx_fifo.size() != 0 ? rx_fifo[0] : 8'h00;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic feed_frame(input logic [31:0] w, input int lo, input int hi);
        logic [7:0] f[5];
        for (int k = 0; k < 4; k++) f[k] = w[8*k +: 8];
        f[4] = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        for (int k = lo; k <= hi; k++) rx_fifo.push_back(f[k]);
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        int i;
        i = 0;
        while (!tx_ready && i < 200) begin step(); i++; end
        ok = tx_ready;
        if (ok) begin
            tx_word = w;
            tx_valid = 1'b1;
            step();
            tx_valid = 1'b0;
            for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
`ifdef UART_WORD_CHECKSUM_EN
            exp_tx.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
        end
    endtask

    task automatic wait_rx(output logic [31:0] w, output bit ok);
        int i;
        i = 0;
        while (!rx_valid && i < 400) begin step(); i++; end
        ok = rx_valid;
        w = rx_word;
        if (ok) begin
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int i;
        i = 0;
        while (tx_seen.size() < n && i < 800) begin step(); i++; end
        ok = tx_seen.size() >= n;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        checks += 7;
        if (recv_flag !== 1'b0) begin failures++; $display("FAIL reset_recv_flag got %b want 0", recv_flag); end
        if (send_flag !== 1'b0) begin failures++; $display("FAIL reset_send_flag got %b want 0", send_flag); end
        if (send_data !== 8'h00) begin failures++; $display("FAIL reset_send_data got %h want 00", send_data); end
        if (rx_word !== 32'h0) begin failures++; $display("FAIL reset_rx_word got %h want 0", rx_word); end
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_tx_word();
        bit ok;
        logic [7:0] e;
        sendable = 1'b1;
        send_word(32'hDEADBEEF, ok);
        wait_tx(NB, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL tx_word_count got %0d want %0d", tx_seen.size(), NB); end
        checks++;
        if (tx_seen.size() != 0 && tx_seen[0] !== 8'hEF) begin failures++; $display("FAIL tx_first_byte got %h want ef", tx_seen[0]); end
        while (tx_seen.size() != 0 && exp_tx.size() != 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (tx_seen[0] !== e) begin failures++; $display("FAIL tx_byte got %h want %h", tx_seen[0], e); end
            void'(tx_seen.pop_front());
        end
        step();
        checks++;
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL tx_ready_after got %b want 1", tx_ready); end
    endtask

    task automatic test_rx_hold();
        bit ok;
        logic [31:0] w;
        int p0;
        rx_ready = 1'b0;
        p0 = pops;
        feed_frame(32'h12345678, 0, NB - 1);
        exp_rx.push_back(32'h12345678);
        for (int i = 0; i < 200 && !rx_valid; i++) step();
        checks += 2;
        if (rx_valid !== 1'b1) begin failures++; $display("FAIL rx_hold_valid got %b want 1", rx_valid); end
        if (rx_word !== 32'h12345678) begin failures++; $display("FAIL rx_hold_word got %h want 12345678", rx_word); end
        feed_frame(32'hFFFFFFFF, 0, 0);
        for (int i = 0; i < 20; i++) step();
        checks += 2;
        if (pops - p0 != NB) begin failures++; $display("FAIL rx_hold_pops got %0d want %0d", pops - p0, NB); end
        if (rx_valid !== 1'b1) begin failures++; $display("FAIL rx_hold_stays got %b want 1", rx_valid); end
        wait_rx(w, ok);
        checks++;
        if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL rx_hold_accept got %h want %h", w, exp_rx[0]); end
        void'(exp_rx.pop_front());
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL rx_after_accept got %b want 0", rx_valid); end
        for (int i = 0; i < 8; i++) step();
        rx_fifo.delete();
        for (int i = 0; i < TO + 10; i++) step();
    endtask

    task automatic test_timeout();
        bit ok;
        logic [31:0] w;
        int p0;
        p0 = pops;
        rx_fifo.push_back(8'hAA);
        rx_fifo.push_back(8'hBB);
        for (int i = 0; i < 50 && pops - p0 < 2; i++) step();
        for (int i = 0; i < TO + 10; i++) step();
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL timeout_no_valid got %b want 0", rx_valid); end
        feed_frame(32'h04030201, 0, NB - 1);
        exp_rx.push_back(32'h04030201);
        wait_rx(w, ok);
        checks += 2;
        if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL timeout_word got %h want %h", w, exp_rx[0]); end
        if (w !== 32'h04030201) begin failures++; $display("FAIL timeout_literal got %h want 04030201", w); end
        void'(exp_rx.pop_front());
        checks++;
        if (errs !== 0) begin failures++; $display("FAIL timeout_rx_err got %0d want 0", errs); end
        // a pause shorter than TIMEOUT keeps the partial word
        p0 = pops;
        feed_frame(32'h44332211, 0, 1);
        exp_rx.push_back(32'h44332211);
        for (int i = 0; i < 50 && pops - p0 < 2; i++) step();
        for (int i = 0; i < TO - 10; i++) step();
        feed_frame(32'h44332211, 2, NB - 1);
        wait_rx(w, ok);
        checks++;
        if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL short_pause_word got %h want %h", w, exp_rx[0]); end
        void'(exp_rx.pop_front());
    endtask

    task automatic test_tx_stall();
        bit ok;
        int p0;
        logic [7:0] e;
        p0 = pushes;
        sendable = 1'b1;
        send_word(32'hA1B2C3D4, ok);
        for (int i = 0; i < 100 && pushes - p0 < 2; i++) step();
        sendable = 1'b0;
        for (int i = 0; i < 100; i++) step();
        checks++;
        if (pushes - p0 != 2) begin failures++; $display("FAIL tx_stall_pushes got %0d want 2", pushes - p0); end
        sendable = 1'b1;
        wait_tx(NB, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL tx_stall_resume got %0d want %0d", tx_seen.size(), NB); end
        while (tx_seen.size() != 0 && exp_tx.size() != 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (tx_seen[0] !== e) begin failures++; $display("FAIL tx_stall_byte got %h want %h", tx_seen[0], e); end
            void'(tx_seen.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] w;
        logic [7:0] e;
        sendable = 1'b1;
        feed_frame(32'hCAFEF00D, 0, NB - 1);
        exp_rx.push_back(32'hCAFEF00D);
        feed_frame(32'h0BADBEEF, 0, NB - 1);
        exp_rx.push_back(32'h0BADBEEF);
        send_word(32'h13579BDF, ok);
        send_word(32'h2468ACE0, ok);
        for (int n = 0; n < 2; n++) begin
            wait_rx(w, ok);
            checks++;
            if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL b2b_rx_word got %h want %h", w, exp_rx[0]); end
            void'(exp_rx.pop_front());
        end
        wait_tx(2 * NB, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_tx_count got %0d want %0d", tx_seen.size(), 2 * NB); end
        while (tx_seen.size() != 0 && exp_tx.size() != 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (tx_seen[0] !== e) begin failures++; $display("FAIL b2b_tx_byte got %h want %h", tx_seen[0], e); end
            void'(tx_seen.pop_front());
        end
    endtask

`ifdef UART_WORD_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        logic [31:0] w;
        int e0, p0, vcnt;
        feed_frame(32'h04030201, 0, 4);
        exp_rx.push_back(32'h04030201);
        wait_rx(w, ok);
        checks++;
        if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL chk_good_word got %h want %h", w, exp_rx[0]); end
        void'(exp_rx.pop_front());
        e0 = errs;
        p0 = pops;
        vcnt = 0;
        for (int k = 1; k <= 5; k++) rx_fifo.push_back(8'(k));
        for (int i = 0; i < 60; i++) begin
            step();
            if (rx_valid) vcnt++;
        end
        checks += 3;
        if (errs - e0 != 1) begin failures++; $display("FAIL chk_bad_err got %0d want 1", errs - e0); end
        if (vcnt != 0) begin failures++; $display("FAIL chk_bad_valid got %0d want 0", vcnt); end
        if (pops - p0 != 5) begin failures++; $display("FAIL chk_bad_pops got %0d want 5", pops - p0); end
        feed_frame(32'h89ABCDEF, 0, 4);
        exp_rx.push_back(32'h89ABCDEF);
        wait_rx(w, ok);
        checks++;
        if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL chk_after_err got %h want %h", w, exp_rx[0]); end
        void'(exp_rx.pop_front());
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] w;
        logic [7:0] e;
        int p0, q0;
        p0 = pops;
        q0 = pushes;
        sendable = 1'b1;
        send_word(32'h55667788, ok);
        feed_frame(32'h99AABBCC, 0, 2);
        for (int i = 0; i < 100 && pushes - q0 < 2; i++) step();
        sendable = 1'b0;
        for (int i = 0; i < 100 && pops - p0 < 3; i++) step();
        RST = 1'b1;
        #1;
        checks += 7;
        if (recv_flag !== 1'b0) begin failures++; $display("FAIL mid_recv_flag got %b want 0", recv_flag); end
        if (send_flag !== 1'b0) begin failures++; $display("FAIL mid_send_flag got %b want 0", send_flag); end
        if (send_data !== 8'h00) begin failures++; $display("FAIL mid_send_data got %h want 00", send_data); end
        if (rx_word !== 32'h0) begin failures++; $display("FAIL mid_rx_word got %h want 0", rx_word); end
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rx_valid got %b want 0", rx_valid); end
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL mid_tx_ready got %b want 1", tx_ready); end
        if (rx_err !== 1'b0) begin failures++; $display("FAIL mid_rx_err got %b want 0", rx_err); end
        rx_fifo.delete();
        tx_seen.delete();
        exp_tx.delete();
        exp_rx.delete();
        step();
        step();
        RST = 1'b0;
        sendable = 1'b1;
        q0 = pushes;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (pushes != q0) begin failures++; $display("FAIL mid_no_emit got %0d want %0d", pushes, q0); end
        feed_frame(32'hFEDCBA98, 0, NB - 1);
        exp_rx.push_back(32'hFEDCBA98);
        send_word(32'h31415926, ok);
        wait_rx(w, ok);
        checks++;
        if (!ok || w !== exp_rx[0]) begin failures++; $display("FAIL mid_rx_after got %h want %h", w, exp_rx[0]); end
        void'(exp_rx.pop_front());
        wait_tx(NB, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_tx_count got %0d want %0d", tx_seen.size(), NB); end
        while (tx_seen.size() != 0 && exp_tx.size() != 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (tx_seen[0] !== e) begin failures++; $display("FAIL mid_tx_byte got %h want %h", tx_seen[0], e); end
            void'(tx_seen.pop_front());
        end
    endtask

    task automatic test_pulse_gap();
        checks += 2;
        if (gap_viol != 0) begin failures++; $display("FAIL pulse_gap got %0d want 0", gap_viol); end
        if (tx_seen.size() != 0) begin failures++; $display("FAIL extra_tx_bytes got %0d want 0", tx_seen.size()); end
    endtask

    initial begin
        test_reset();
        test_tx_word();
        test_rx_hold();
        test_timeout();
        test_tx_stall();
        test_back_to_back();
`ifdef UART_WORD_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        for (int i = 0; i < 20; i++) step();
        test_pulse_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
